// File: rtl/equeue_int_pkg.sv
// Shared types for the execution issue queues: field widths, the queue entry
// record, and the CDB wakeup applied to an entry.
package equeue_int_pkg;

  localparam int OPCODE_W = 4;
  localparam int TAG_W    = 6;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic                valid;
    logic [OPCODE_W-1:0] opcode;
    logic [TAG_W-1:0]    rdtag;
    logic [TAG_W-1:0]    rstag;
    logic [DATA_W-1:0]   rsdata;
    logic                rsvalid;
    logic [TAG_W-1:0]    rttag;
    logic [DATA_W-1:0]   rtdata;
    logic                rtvalid;
  } iq_entry_t;

  // Captures a matching broadcast into any still-waiting operand; operands
  // that are already valid keep their value.
  function automatic iq_entry_t cdb_wake(input iq_entry_t         e,
                                         input logic              cdb_valid,
                                         input logic [TAG_W-1:0]  cdb_tag,
                                         input logic [DATA_W-1:0] cdb_data);
    iq_entry_t w;
    w = e;
    if (e.valid && cdb_valid) begin
      if (!e.rsvalid && e.rstag == cdb_tag) begin
        w.rsvalid = 1'b1;
        w.rsdata  = cdb_data;
      end
      if (!e.rtvalid && e.rttag == cdb_tag) begin
        w.rtvalid = 1'b1;
        w.rtdata  = cdb_data;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/equeue_int_entry.sv
// One issue-queue slot: registers whatever the top selects for it this cycle,
// after applying the CDB tag compare and operand capture.
module equeue_int_entry
  import equeue_int_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  iq_entry_t         next_in,
  output iq_entry_t         entry_q
);

  iq_entry_t entry_d;

  always_comb begin
    entry_d = cdb_wake(next_in, cdb_valid, cdb_tag, cdb_data);
  end

  // NOTE: the whole entry is cleared, not only the valid bit; the payload is
  // small and a zeroed slot keeps every downstream mux X-free after reset.
  // NOTE: non-blocking assignment so every slot samples its neighbour's old
  // value during a shift, independent of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) entry_q <= '0;
    else       entry_q <= entry_d;
  end

endmodule

// File: rtl/equeue_int.sv
// Integer issue queue: age-ordered slots with compaction on issue, append on
// dispatch, CDB wakeup, and oldest-ready selection toward the issue unit.
module equeue_int
  import equeue_int_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] dispatch_opcode,
  input  logic                dispatch_en,
  output logic                dispatch_ready,
  input  logic [TAG_W-1:0]    dispatch_rdtag,
  input  logic [TAG_W-1:0]    dispatch_rstag,
  input  logic [TAG_W-1:0]    dispatch_rttag,
  input  logic [DATA_W-1:0]   dispatch_rsdata,
  input  logic [DATA_W-1:0]   dispatch_rtdata,
  input  logic                dispatch_rsvalid,
  input  logic                dispatch_rtvalid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic                cdb_valid,
  input  logic [DATA_W-1:0]   cdb_data,
  output logic [OPCODE_W-1:0] issueint_opcode,
  output logic [TAG_W-1:0]    issueint_rdtag,
  output logic [DATA_W-1:0]   issueint_rsdata,
  output logic [DATA_W-1:0]   issueint_rtdata,
  output logic                issueint_ready,
  input  logic                issueint_done
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  iq_entry_t        entry_q [DEPTH];
  iq_entry_t        next_in [DEPTH];
  iq_entry_t        ext     [DEPTH+1];
  iq_entry_t        disp_entry;
  iq_entry_t        sel_entry;
  logic             found;
  logic [CNT_W-1:0] sel_idx;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W-1:0] count_q, count_d;
  logic             issue;
  logic             accept;

  assign dispatch_ready = (count_q < CNT_W'(DEPTH));

  always_comb begin
    disp_entry         = '0;
    disp_entry.valid   = 1'b1;
    disp_entry.opcode  = dispatch_opcode;
    disp_entry.rdtag   = dispatch_rdtag;
    disp_entry.rstag   = dispatch_rstag;
    disp_entry.rsdata  = dispatch_rsdata;
    disp_entry.rsvalid = dispatch_rsvalid;
    disp_entry.rttag   = dispatch_rttag;
    disp_entry.rtdata  = dispatch_rtdata;
    disp_entry.rtvalid = dispatch_rtvalid;
  end

  // NOTE: every variable gets a default before the loops so no path through
  // this block leaves one unassigned, which would infer a latch.
  always_comb begin
    found     = 1'b0;
    sel_idx   = '0;
    sel_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && entry_q[i].valid && entry_q[i].rsvalid && entry_q[i].rtvalid) begin
        found     = 1'b1;
        sel_idx   = CNT_W'(i);
        sel_entry = entry_q[i];
      end
    end
  end

  assign issue  = found && issueint_done;
  assign accept = dispatch_en && dispatch_ready;
  // The new entry lands after compaction, one slot lower when an issue frees one.
  assign wr_idx = count_q - CNT_W'(issue);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ext[i] = entry_q[i];
    ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      next_in[i] = (issue && CNT_W'(i) >= sel_idx) ? ext[i+1] : ext[i];
      if (accept && CNT_W'(i) == wr_idx) next_in[i] = disp_entry;
    end
    count_d = count_q + CNT_W'(accept) - CNT_W'(issue);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    equeue_int_entry u_entry (
      .clk       (clk),
      .reset     (reset),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .next_in   (next_in[g]),
      .entry_q   (entry_q[g])
    );
  end

  assign issueint_ready  = found;
  assign issueint_opcode = sel_entry.opcode;
  assign issueint_rdtag  = sel_entry.rdtag;
  assign issueint_rsdata = sel_entry.rsdata;
  assign issueint_rtdata = sel_entry.rtdata;

endmodule

// File: tb/tb_equeue_int.sv
// Directed self-checking bench for equeue_int: reset, idle, overfill/drain,
// concurrent flow, single entry, CDB wakeup and mid-run reset.
module tb_equeue_int;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  dispatch_opcode;
  logic        dispatch_en;
  logic        dispatch_ready;
  logic [5:0]  dispatch_rdtag, dispatch_rstag, dispatch_rttag;
  logic [31:0] dispatch_rsdata, dispatch_rtdata;
  logic        dispatch_rsvalid, dispatch_rtvalid;
  logic [5:0]  cdb_tag;
  logic        cdb_valid;
  logic [31:0] cdb_data;
  logic [3:0]  issueint_opcode;
  logic [5:0]  issueint_rdtag;
  logic [31:0] issueint_rsdata, issueint_rtdata;
  logic        issueint_ready;
  logic        issueint_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [74:0] obs;
  assign obs = {issueint_ready, issueint_opcode, issueint_rdtag, issueint_rsdata, issueint_rtdata};

  equeue_int #(.DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .dispatch_opcode  (dispatch_opcode),
    .dispatch_en      (dispatch_en),
    .dispatch_ready   (dispatch_ready),
    .dispatch_rdtag   (dispatch_rdtag),
    .dispatch_rstag   (dispatch_rstag),
    .dispatch_rttag   (dispatch_rttag),
    .dispatch_rsdata  (dispatch_rsdata),
    .dispatch_rtdata  (dispatch_rtdata),
    .dispatch_rsvalid (dispatch_rsvalid),
    .dispatch_rtvalid (dispatch_rtvalid),
    .cdb_tag          (cdb_tag),
    .cdb_valid        (cdb_valid),
    .cdb_data         (cdb_data),
    .issueint_opcode  (issueint_opcode),
    .issueint_rdtag   (issueint_rdtag),
    .issueint_rsdata  (issueint_rsdata),
    .issueint_rtdata  (issueint_rtdata),
    .issueint_ready   (issueint_ready),
    .issueint_done    (issueint_done)
  );

  always #5 clk = ~clk;

  function automatic logic [74:0] expo(input logic rdy, input int op, input int tag,
                                       input int rs, input int rt);
    logic [3:0]  o;
    logic [5:0]  t;
    logic [31:0] a, b;
    o = op[3:0];
    t = tag[5:0];
    a = rs;
    b = rt;
    return {rdy, o, t, a, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input int v, input logic vld);
    dispatch_opcode  = v[3:0];
    dispatch_rdtag   = v[5:0];
    dispatch_rstag   = v[5:0];
    dispatch_rttag   = v[5:0];
    dispatch_rsdata  = v;
    dispatch_rtdata  = v;
    dispatch_rsvalid = vld;
    dispatch_rtvalid = vld;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dispatch_en = 1'b0; issueint_done = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    set_disp(0, 1'b0);
    step();
    step();
    n_checks++;
    if (obs !== 75'd0 || dispatch_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset: obs=%h dispatch_ready=%b, want obs=0 dispatch_ready=1", obs, dispatch_ready);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      set_disp(int'($urandom_range(0, 63)), 1'b1);
      cdb_valid = k[0];
      cdb_tag   = 6'($urandom_range(0, 63));
      cdb_data  = $urandom;
      step();
      n_checks++;
      if (issueint_ready !== 1'b0 || dispatch_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL idle[%0d]: issueint_ready=%b dispatch_ready=%b, want 0/1", k, issueint_ready, dispatch_ready);
      end
    end
    cdb_valid = 1'b0;
  endtask

  task automatic test_overfill_drain();
    issueint_done = 1'b0;
    for (int i = 5; i <= 14; i++) begin
      n_checks++;
      if (dispatch_ready !== (i < 9)) begin
        n_errors++;
        $display("FAIL overfill_ready[%0d]: got %b want %b", i, dispatch_ready, (i < 9));
      end
      set_disp(i, 1'b1);
      dispatch_en = 1'b1;
      step();
    end
    dispatch_en = 1'b0;
    issueint_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs !== expo(1'b1, 5 + k, 5 + k, 5 + k, 5 + k)) begin
        n_errors++;
        $display("FAIL drain[%0d]: got %h want %h", k, obs, expo(1'b1, 5 + k, 5 + k, 5 + k, 5 + k));
      end
      step();
    end
    n_checks++;
    if (obs !== 75'd0 || dispatch_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL drain_empty: obs=%h dispatch_ready=%b, want 0/1", obs, dispatch_ready);
    end
    issueint_done = 1'b0;
  endtask

  task automatic test_back_to_back();
    issueint_done = 1'b1;
    for (int i = 5; i <= 14; i++) begin
      n_checks++;
      if (dispatch_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", i, dispatch_ready);
      end
      n_checks++;
      if (obs !== ((i == 5) ? 75'd0 : expo(1'b1, i - 1, i - 1, i - 1, i - 1))) begin
        n_errors++;
        $display("FAIL b2b_issue[%0d]: got %h", i, obs);
      end
      set_disp(i, 1'b1);
      dispatch_en = 1'b1;
      step();
    end
    dispatch_en = 1'b0;
    n_checks++;
    if (obs !== expo(1'b1, 14, 14, 14, 14)) begin
      n_errors++;
      $display("FAIL b2b_last: got %h want %h", obs, expo(1'b1, 14, 14, 14, 14));
    end
    step();
    n_checks++;
    if (obs !== 75'd0) begin
      n_errors++;
      $display("FAIL b2b_empty: got %h want 0", obs);
    end
    issueint_done = 1'b0;
  endtask

  task automatic test_single();
    issueint_done = 1'b1;
    set_disp(5, 1'b1);
    dispatch_en = 1'b1;
    step();
    dispatch_en = 1'b0;
    n_checks++;
    if (obs !== expo(1'b1, 5, 5, 5, 5)) begin
      n_errors++;
      $display("FAIL single_present: got %h want %h", obs, expo(1'b1, 5, 5, 5, 5));
    end
    step();
    n_checks++;
    if (obs !== 75'd0 || dispatch_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL single_empty: obs=%h dispatch_ready=%b, want 0/1", obs, dispatch_ready);
    end
    issueint_done = 1'b0;
  endtask

  task automatic test_cdb_wakeup();
    issueint_done = 1'b0;
    cdb_valid = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      set_disp(i, 1'b0);
      dispatch_en = 1'b1;
      step();
    end
    dispatch_en = 1'b0;
    n_checks++;
    if (obs !== 75'd0 || dispatch_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL cdb_waiting: obs=%h dispatch_ready=%b, want 0/0", obs, dispatch_ready);
    end
    for (int i = 5; i <= 14; i++) begin
      cdb_tag   = i[5:0];
      cdb_data  = i * 1000;
      cdb_valid = i[0];
      step();
    end
    cdb_valid = 1'b0;
    n_checks++;
    if (obs !== expo(1'b1, 5, 5, 5000, 5000)) begin
      n_errors++;
      $display("FAIL cdb_first: got %h want %h", obs, expo(1'b1, 5, 5, 5000, 5000));
    end
    issueint_done = 1'b1;
    step();
    n_checks++;
    if (obs !== expo(1'b1, 7, 7, 7000, 7000)) begin
      n_errors++;
      $display("FAIL cdb_second: got %h want %h", obs, expo(1'b1, 7, 7, 7000, 7000));
    end
    step();
    n_checks++;
    if (obs !== 75'd0 || dispatch_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL cdb_leftover: obs=%h dispatch_ready=%b, want 0/1", obs, dispatch_ready);
    end
    issueint_done = 1'b0;

    // Wakeup of the instruction being dispatched, then a broadcast that must
    // not overwrite an operand that was already valid.
    dispatch_opcode  = 4'd9;
    dispatch_rdtag   = 6'd9;
    dispatch_rstag   = 6'd20;
    dispatch_rsvalid = 1'b0;
    dispatch_rsdata  = 32'd0;
    dispatch_rttag   = 6'd21;
    dispatch_rtvalid = 1'b1;
    dispatch_rtdata  = 32'd9;
    dispatch_en      = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_data = 32'd123;
    step();
    dispatch_en = 1'b0;
    cdb_tag = 6'd21; cdb_data = 32'd777;
    n_checks++;
    if (obs !== expo(1'b1, 9, 9, 123, 9)) begin
      n_errors++;
      $display("FAIL cdb_dispatch: got %h want %h", obs, expo(1'b1, 9, 9, 123, 9));
    end
    step();
    cdb_valid = 1'b0;
    n_checks++;
    if (obs !== expo(1'b1, 9, 9, 123, 9)) begin
      n_errors++;
      $display("FAIL cdb_no_overwrite: got %h want %h", obs, expo(1'b1, 9, 9, 123, 9));
    end
  endtask

  task automatic test_reset_mid();
    n_checks++;
    if (dispatch_ready !== 1'b1 || issueint_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_before: dispatch_ready=%b issueint_ready=%b, want 1/1", dispatch_ready, issueint_ready);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 75'd0 || dispatch_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_async: obs=%h dispatch_ready=%b, want 0/1", obs, dispatch_ready);
    end
    step();
    reset = 1'b0;
    set_disp(30, 1'b1);
    dispatch_en = 1'b1;
    step();
    dispatch_en = 1'b0;
    n_checks++;
    if (obs !== expo(1'b1, 30, 30, 30, 30) || dispatch_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_redispatch: got %h dispatch_ready=%b want %h/1", obs, dispatch_ready, expo(1'b1, 30, 30, 30, 30));
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_overfill_drain();
    test_back_to_back();
    test_single();
    test_cdb_wakeup();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/equeue_int.md
# equeue_int

Integer-execution issue queue of the out-of-order MIPS core, between dispatch and the integer issue unit. Holds up to DEPTH dispatched integer instructions with renamed source tags and operands. Snoops the common data bus (CDB) to wake waiting operands. Presents the oldest instruction whose operands are both valid to the integer issue unit.

## Interface
- DEPTH, 4: number of queue entries.
- clk  in  1  rising-edge clock; one clock domain.
- reset  in  1  asynchronous, active-high; clears the queue.
- dispatch_opcode  in  4  integer ALU opcode of the incoming instruction.
- dispatch_en  in  1  dispatch request; accepted only when dispatch_ready=1.
- dispatch_ready  out  1  queue not full.
- dispatch_rdtag  in  6  destination physical tag.
- dispatch_rstag, dispatch_rttag  in  6 each  source tags.
- dispatch_rsdata, dispatch_rtdata  in  32 each  source values; meaningful only when the matching valid bit is 1.
- dispatch_rsvalid, dispatch_rtvalid  in  1 each  source value already available.
- cdb_tag  in  6  tag being broadcast on the CDB.
- cdb_valid  in  1  CDB broadcast qualifier.
- cdb_data  in  32  broadcast value.
- issueint_opcode  out  4  opcode of the selected entry.
- issueint_rdtag  out  6  destination tag of the selected entry.
- issueint_rsdata, issueint_rtdata  out  32 each  operands of the selected entry.
- issueint_ready  out  1  a fully-ready entry is presented.
- issueint_done  in  1  issue unit takes the presented entry this cycle.

## Operation
- Each entry holds: valid, opcode, rdtag, rstag, rsdata, rsvalid, rttag, rtdata, rtvalid. Entries are kept in age order, with index 0 the oldest.
- **Select:** combinational. The lowest-index valid entry with rsvalid and rtvalid both set drives the issueint_* outputs, and issueint_ready=1. If no such entry exists, issueint_ready=0 and the data, tag and opcode outputs are 0.
- **Issue:** at the edge where issueint_ready and issueint_done are both 1, the selected entry is removed. Younger entries shift down one position, preserving age order. issueint_done with issueint_ready=0 is ignored.
- **Dispatch:** dispatch_ready = (count < DEPTH), from registered state only. At the edge where dispatch_en and dispatch_ready are both 1, the instruction is appended as the youngest entry. dispatch_en while full is dropped, with no state change.
- **Simultaneous issue and dispatch:** both take effect. The new entry is placed after compaction. A full queue still reports dispatch_ready=0 in that cycle.
- **CDB wakeup:** every cycle with cdb_valid=1, each valid entry updates its operands. For each operand with valid=0 and tag == cdb_tag, the entry captures cdb_data and sets that operand's valid bit. Operands already valid are never overwritten.
- **CDB during dispatch:** the same wakeup applies to the instruction being dispatched in that cycle. An invalid source whose tag matches the CDB is stored as valid with cdb_data.
- **Empty slots:** removed and empty slots have their valid bit cleared; their other contents are don't-care.

## Timing
- **Reset:** all entries invalid. dispatch_ready=1, issueint_ready=0, all issueint data, tag and opcode outputs 0. Reset asserted mid-operation flushes every entry immediately.
- **Dispatch to issue:** minimum 1 cycle. An entry written at edge N, with both operands valid, raises issueint_ready after edge N.
- **CDB to issue:** 1 cycle. A wakeup at edge N makes the entry selectable after edge N.
- **Issue throughput:** one entry removed per cycle. With issueint_done held high and every entry ready, a full queue drains in DEPTH cycles.
- **Selection with the same data:** the outputs update combinationally after each removal, so the next-oldest ready entry is presented in the following cycle.

## Structure
- **Shared package:** OPCODE_W=4, TAG_W=6, DATA_W=32, and an entry struct/typedef shared with the other execution queues.
- **Sub-module:** equeue_int_entry, one entry's storage plus CDB tag compare and operand capture, instantiated DEPTH times. The top level holds the shift/compaction control, the count, and the oldest-ready priority select.

## Test plan
- **Idle:** dispatch_en=0 and issueint_done=0 for 10 cycles with varying inputs -> queue stays empty, issueint_ready=0, dispatch_ready=1.
- **Overfill then drain:** dispatch opcodes/tags/data 5..14 with both valids=1 and done=0 -> entries 5..8 held. dispatch_ready drops after the 4th accept, and 9..14 are dropped. Then hold done=1 -> issues 5,6,7,8 in order (rdtag=opcode=rsdata=rtdata=i), then issueint_ready=0.
- **Concurrent fill and drain:** dispatch 5..14 with done=1 every cycle -> each value issues exactly once, in order, one cycle after its dispatch. No drops, and the queue never fills.
- **Single entry:** dispatch 5 with done=1 -> presented the next cycle, removed, and the queue is empty again with dispatch_ready=1.
- **CDB wakeup:** dispatch 5..8 with both valids=0 -> issueint_ready=0. Broadcast tags 5..14 with data=i*1000 and cdb_valid=i%2 (odd tags only) -> only entry 5 ("rs/rt"=5000) and entry 7 (7000) become ready. With done=1 they issue in order 5 then 7; entries 6 and 8 remain.
- **Reset mid-operation:** assert reset with 3 valid entries -> outputs return to reset values asynchronously, and the next dispatch lands at index 0.
